game_round_ctrl: RTL
====================

# game_round_ctrl

Round controller that sequences the 0.1 s game clock block and shares its per-tick write slot among several requesters. It owns the game clock's enable, clear and speed-select inputs, counts down a fixed round length in ticks, and issues at most one round-robin write grant per tick. Sits between the board keys/game logic and the game clock block, clocked from the 50 MHz board clock.

## Interface
- NREQ, 4, number of write requesters (2..8)
- ROUND_TICKS, 600, round length in ticks (60 s at normal speed); must be ≥ 1 and < 2^TICK_W
- WARN_TICKS, 100, remaining-tick threshold at and below which the clock runs double speed; must be < ROUND_TICKS
- TICK_W, 10, width of remaining-tick counter

- CLOCK50M  in  1  system clock, 50 MHz
- KEY0  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a new round
- pause  in  1  one-cycle pulse: toggle RUN/PAUSE
- tick  in  1  one-cycle strobe from game clock (counter_update)
- req  in  NREQ  write requests, level, held until granted
- clk_enable  out  1  game clock enable (drives SWITCH[0])
- clk_clear  out  1  one-cycle pulse clearing game clock counter
- speed  out  2  game clock rate select (drives SWITCH[2:1])
- grant  out  NREQ  one-hot write grant, one-cycle pulse
- state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3
- remaining  out  TICK_W  ticks left in round
- round_over  out  1  one-cycle pulse at round end

## Operation
- IDLE: start → RUN; remaining ← ROUND_TICKS; clk_clear pulses.
- RUN: each tick: remaining −1, one grant issued if any req. remaining reaches 0 → OVER, round_over pulses. pause → PAUSE.
- PAUSE: pause → RUN; start ignored; tick ignored.
- OVER: start → RUN (as from IDLE); pause ignored.
- clk_enable = 1 only in RUN (decoded from state register).
- speed = 2'd1 in RUN when remaining ≤ WARN_TICKS, else 2'd0; 2'd0 outside RUN.
- Arbitration: round-robin, pointer starts at 0; requester with lowest index ≥ pointer (wrapping) wins; pointer ← winner+1 mod NREQ. Pointer holds when nothing is granted.
- Ticks outside RUN produce no decrement and no grant.
- Simultaneous events: start+pause in IDLE/OVER → start wins; in RUN start ignored, pause acts. tick+pause in RUN → tick fully processed (decrement, grant), then PAUSE. Tick that brings remaining to 0 still issues its grant; OVER takes priority over a same-cycle pause.
- Requester must drop req the cycle after seeing its grant; a still-held req is eligible again next tick at the rotated priority.

## Timing
- Reset (KEY0 high, sampled on CLOCK50M): next cycle state=IDLE, clk_enable=0, clk_clear=0, speed=0, grant=0, remaining=0, round_over=0, pointer=0. Reset mid-round aborts without round_over.
- start at cycle N → state=RUN, clk_enable=1, clk_clear=1, remaining=ROUND_TICKS at N+1; clk_clear low at N+2.
- tick at N → remaining decremented and grant valid at N+1, grant low at N+2.
- Final tick at N → remaining=0, state=OVER, round_over=1, clk_enable=0 at N+1.
- speed changes in the same cycle remaining crosses WARN_TICKS.

## Structure
- Shared package game_pkg: state encodings, speed codes (SPEED_NORMAL=0, SPEED_X2=1).
- Sub-module rr_arbiter (parameter NREQ; inputs req, advance; output one-hot grant; internal pointer).

## Test plan
- Reset, then start → N+1: state=1, clk_enable=1, clk_clear=1, remaining=600; N+2 clk_clear=0.
- ROUND_TICKS=5, WARN_TICKS=2, five ticks → remaining 4,3,2(speed=1),1,0; round_over one pulse, state=3, clk_enable=0.
- req=4'b1111 held, four ticks → grants 0001,0010,0100,1000; fifth tick → 0001.
- req=4'b0100 only, tick → grant=0100; pointer=3; then req=4'b0101 → grant=0001.
- pause mid-round, three ticks → remaining unchanged, no grants; pause again → RUN, ticks resume decrement.
- KEY0 during RUN with remaining=300 and tick same cycle → next cycle all outputs zero, state=0, no grant.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game round controller: FSM state
// encodings and the speed-select codes driven to the game clock.
package game_pkg;

  // Round FSM states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Game clock rate select codes.
  localparam logic [1:0] SPEED_NORMAL = 2'd0;
  localparam logic [1:0] SPEED_X2     = 2'd1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The requester with the lowest index at or above
// the pointer (wrapping) wins. The pointer moves to winner+1 only when
// advance_i is high and some request is present; otherwise it holds.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          found;

  // Pick the winner: first scan from the pointer upward, then wrap to 0.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i >= int'(ptr_q)) && req_i[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    if (found) begin
      grant_o = NREQ'(1) << win;
    end
    if (advance_i && found) begin
      ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Game round controller: sequences the 0.1 s game clock (enable, clear,
// speed select), counts a round down in ticks, and hands out at most one
// round-robin write grant per tick while running.
//
// Handshake: req is a level held by a requester until it sees its grant;
// grant is a registered one-hot pulse lasting one cycle, valid the cycle
// after the tick that produced it. A requester must drop req the cycle
// after its grant; a req still held is simply eligible again on the next
// tick at the rotated priority.
import game_pkg::*;

module game_round_ctrl #(
  parameter int NREQ        = 4,
  parameter int ROUND_TICKS = 600,
  parameter int WARN_TICKS  = 100,
  parameter int TICK_W      = 10
) (
  input  logic              CLOCK50M,
  input  logic              KEY0,
  input  logic              start,
  input  logic              pause,
  input  logic              tick,
  input  logic [NREQ-1:0]   req,
  output logic              clk_enable,
  output logic              clk_clear,
  output logic [1:0]        speed,
  output logic [NREQ-1:0]   grant,
  output logic [1:0]        state,
  output logic [TICK_W-1:0] remaining,
  output logic              round_over
);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] rem_q, rem_d;
  logic              clr_q, clr_d;
  logic              over_q, over_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   arb_grant;
  logic              advance;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i     (CLOCK50M),
    .rst_i     (KEY0),
    .req_i     (req),
    .advance_i (advance),
    .grant_o   (arb_grant)
  );

  // Next-state logic: start/pause/tick handling with tick taking effect
  // before a same-cycle pause, and round end overriding pause.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    clr_d   = 1'b0;
    over_d  = 1'b0;
    grant_d = '0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          rem_d   = TICK_W'(ROUND_TICKS);
          clr_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          advance = 1'b1;
          grant_d = arb_grant;
          rem_d   = rem_q - 1'b1;
          if (rem_q == TICK_W'(1)) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK50M) begin
    if (KEY0) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      clr_q   <= 1'b0;
      over_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      clr_q   <= clr_d;
      over_q  <= over_d;
      grant_q <= grant_d;
    end
  end

  // Clock control decoded from registers only, so speed follows
  // remaining in the same cycle it crosses the warning threshold.
  always_comb begin
    clk_enable = (state_q == ST_RUN);
    speed      = SPEED_NORMAL;
    if ((state_q == ST_RUN) && (rem_q <= TICK_W'(WARN_TICKS))) begin
      speed = SPEED_X2;
    end
  end

  assign clk_clear  = clr_q;
  assign round_over = over_q;
  assign grant      = grant_q;
  assign state      = state_q;
  assign remaining  = rem_q;

endmodule
